// File: rtl/axis_rr_arbiter.sv
// Purpose : 2-input packet-level round-robin AXI-Stream arbiter feeding one sink.
// Latency : request seen in IDLE at N -> source tready at N+1 -> m00 tvalid at N+2.
// Backpr. : granted source tready = !m00_tvalid || m00_tready; the other source waits.
//
// Ports: m00_axis_aclk / m00_axis_areset (sync, active-high), arb_enable gates new grants;
//        s00/s01_axis_* are the two AXI-Stream sources; m00_axis_* is the registered output;
//        grant_id = owner of the current/most recent packet; busy = a packet is granted.
// Optional: define AXIS_RR_ARBITER_STATS_EN to add per-source packet counters
//           pkt_count0 / pkt_count1 (count accepted tlast beats, wrap at 2^32).
module axis_rr_arbiter #(
  parameter int DATA_SIZE = 32
) (
  input  logic                   m00_axis_aclk,
  input  logic                   m00_axis_areset,
  input  logic                   arb_enable,
  input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
  input  logic [DATA_SIZE/8-1:0] s00_axis_tstrb,
  input  logic                   s00_axis_tvalid,
  input  logic                   s00_axis_tlast,
  output logic                   s00_axis_tready,
  input  logic [DATA_SIZE-1:0]   s01_axis_tdata,
  input  logic [DATA_SIZE/8-1:0] s01_axis_tstrb,
  input  logic                   s01_axis_tvalid,
  input  logic                   s01_axis_tlast,
  output logic                   s01_axis_tready,
  output logic [DATA_SIZE-1:0]   m00_axis_tdata,
  output logic [DATA_SIZE/8-1:0] m00_axis_tstrb,
  output logic                   m00_axis_tvalid,
  output logic                   m00_axis_tlast,
  input  logic                   m00_axis_tready,
  output logic                   grant_id,
  output logic                   busy
`ifdef AXIS_RR_ARBITER_STATS_EN
  ,
  output logic [31:0]            pkt_count0,
  output logic [31:0]            pkt_count1
`endif
);

  localparam int STRB_SIZE = DATA_SIZE / 8;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   grant_id_q, grant_id_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [DATA_SIZE-1:0]   tdata_q, tdata_d;
  logic [STRB_SIZE-1:0]   tstrb_q, tstrb_d;

  logic                   sel_src;
  logic                   sel_tvalid;
  logic                   sel_tlast;
  logic [DATA_SIZE-1:0]   sel_tdata;
  logic [STRB_SIZE-1:0]   sel_tstrb;
  logic                   out_free;
  logic                   accept;

`ifdef AXIS_RR_ARBITER_STATS_EN
  logic [31:0]            pkt_count0_q, pkt_count0_d;
  logic [31:0]            pkt_count1_q, pkt_count1_d;
`endif

  // Source mux follows the granted state; in IDLE the mux output is unused
  // because neither tready can be high.
  assign sel_src    = (state_q == GRANT1);
  assign sel_tvalid = sel_src ? s01_axis_tvalid : s00_axis_tvalid;
  assign sel_tlast  = sel_src ? s01_axis_tlast  : s00_axis_tlast;
  assign sel_tdata  = sel_src ? s01_axis_tdata  : s00_axis_tdata;
  assign sel_tstrb  = sel_src ? s01_axis_tstrb  : s00_axis_tstrb;

  // Output register can take a beat when empty or draining this cycle.
  assign out_free        = !tvalid_q || m00_axis_tready;
  assign s00_axis_tready = (state_q == GRANT0) && out_free;
  assign s01_axis_tready = (state_q == GRANT1) && out_free;
  assign accept          = sel_tvalid && (s00_axis_tready || s01_axis_tready);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tdata_d      = tdata_q;
    tstrb_d      = tstrb_q;

    case (state_q)
      IDLE: begin
        if (arb_enable) begin
          // Source 0 wins when it is alone or when source 1 had the last packet.
          if (s00_axis_tvalid && (!s01_axis_tvalid || last_grant_q)) begin
            state_d    = GRANT0;
            grant_id_d = 1'b0;
          end else if (s01_axis_tvalid) begin
            state_d    = GRANT1;
            grant_id_d = 1'b1;
          end
        end
      end
      GRANT0, GRANT1: begin
        if (accept && sel_tlast) begin
          state_d      = IDLE;
          last_grant_d = sel_src;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load wins over drain so a simultaneous drain+load keeps tvalid high.
    if (accept) begin
      tvalid_d = 1'b1;
      tlast_d  = sel_tlast;
      tdata_d  = sel_tdata;
      tstrb_d  = sel_tstrb;
    end else if (tvalid_q && m00_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

`ifdef AXIS_RR_ARBITER_STATS_EN
  always_comb begin
    pkt_count0_d = pkt_count0_q;
    pkt_count1_d = pkt_count1_q;
    if (accept && sel_tlast) begin
      if (sel_src) pkt_count1_d = pkt_count1_q + 32'd1;
      else         pkt_count0_d = pkt_count0_q + 32'd1;
    end
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      pkt_count0_q <= '0;
      pkt_count1_q <= '0;
    end else begin
      pkt_count0_q <= pkt_count0_d;
      pkt_count1_q <= pkt_count1_d;
    end
  end

  assign pkt_count0 = pkt_count0_q;
  assign pkt_count1 = pkt_count1_q;
`endif

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      tstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
      tstrb_q      <= tstrb_d;
    end
  end

  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tstrb  = tstrb_q;
  assign grant_id        = grant_id_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Purpose : directed, table-driven check of axis_rr_arbiter plus hand-written corner sequences.
// Latency : each table row is one clock; inputs driven on negedge, outputs sampled 1ns later.
// Backpr. : sink ready is part of every row, so stalls are scripted explicitly.
module tb_axis_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [31:0] s0_d, s1_d, m_d;
  logic [3:0]  s0_s, s1_s, m_s;
  logic        s0_v, s0_l, s0_r, s1_v, s1_l, s1_r;
  logic        m_v, m_l, m_r, gid, busy;
`ifdef AXIS_RR_ARBITER_STATS_EN
  logic [31:0] cnt0, cnt1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axis_rr_arbiter #(.DATA_SIZE(32)) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_areset (rst),
    .arb_enable      (en),
    .s00_axis_tdata  (s0_d),
    .s00_axis_tstrb  (s0_s),
    .s00_axis_tvalid (s0_v),
    .s00_axis_tlast  (s0_l),
    .s00_axis_tready (s0_r),
    .s01_axis_tdata  (s1_d),
    .s01_axis_tstrb  (s1_s),
    .s01_axis_tvalid (s1_v),
    .s01_axis_tlast  (s1_l),
    .s01_axis_tready (s1_r),
    .m00_axis_tdata  (m_d),
    .m00_axis_tstrb  (m_s),
    .m00_axis_tvalid (m_v),
    .m00_axis_tlast  (m_l),
    .m00_axis_tready (m_r),
    .grant_id        (gid),
    .busy            (busy)
`ifdef AXIS_RR_ARBITER_STATS_EN
    ,
    .pkt_count0      (cnt0),
    .pkt_count1      (cnt1)
`endif
  );

  typedef struct packed {
    logic rst, en, v0; logic [31:0] d0; logic l0;
    logic v1; logic [31:0] d1; logic l1; logic mrdy;
  } in_t;

  typedef struct packed {
    logic vld, last; logic [31:0] dat; logic [3:0] strb;
    logic r0, r1, gid, busy;
  } out_t;

  typedef struct packed { in_t i; out_t o; } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input logic rst_i, en_i, v0, input logic [31:0] d0, input logic l0,
                               input logic v1, input logic [31:0] d1, input logic l1, mrdy,
                               input logic vld, last, input logic [31:0] dat, input logic [3:0] strb,
                               input logic r0, r1, g, b);
    vec_t v;
    v.i = '{rst: rst_i, en: en_i, v0: v0, d0: d0, l0: l0, v1: v1, d1: d1, l1: l1, mrdy: mrdy};
    v.o = '{vld: vld, last: last, dat: dat, strb: strb, r0: r0, r1: r1, gid: g, busy: b};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] d0, input logic l0,
                       input logic v1, input logic [31:0] d1, input logic l1);
    s0_v = v0; s0_d = d0; s0_l = l0;
    s1_v = v1; s1_d = d1; s1_l = l1;
  endtask

`ifdef AXIS_RR_ARBITER_STATS_EN
  // Sends an n-beat packet from one source; bounded so a stuck grant still ends the run.
  task automatic send_pkt(input int src, input int n);
    int beat = 0;
    int guard = 0;
    while (beat < n && guard < 50) begin
      @(negedge clk);
      if (src == 0) drive(1'b1, beat, beat == n - 1, 1'b0, 0, 1'b0);
      else          drive(1'b0, 0, 1'b0, 1'b1, beat, beat == n - 1);
      #1;
      if ((src == 0) ? s0_r : s1_r) beat++;
      guard++;
    end
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_pkt src%0d: timed out after %0d cycles, expected completion", src, guard);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    out_t act;

    rst = 1'b1; en = 1'b0; m_r = 1'b1;
    s0_s = 4'hF; s1_s = 4'h5;
    drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);

    //             rst en v0 d0    l0 v1 d1    l1 mr | vld lst dat   strb r0 r1 gid bsy
    // Single 4-beat packet from s00
    tbl.push_back(row(0,1,0,'h00, 0,0,'h00, 0,1, 0,0,'h00,4'h0,0,0,0,0));
    tbl.push_back(row(0,1,1,'h10, 0,0,'h00, 0,1, 0,0,'h00,4'h0,0,0,0,0));
    tbl.push_back(row(0,1,1,'h10, 0,0,'h00, 0,1, 0,0,'h00,4'h0,1,0,0,1));
    tbl.push_back(row(0,1,1,'h11, 0,0,'h00, 0,1, 1,0,'h10,4'hF,1,0,0,1));
    tbl.push_back(row(0,1,1,'h12, 0,0,'h00, 0,1, 1,0,'h11,4'hF,1,0,0,1));
    tbl.push_back(row(0,1,1,'h13, 1,0,'h00, 0,1, 1,0,'h12,4'hF,1,0,0,1));
    tbl.push_back(row(0,1,0,'h00, 0,0,'h00, 0,1, 1,1,'h13,4'hF,0,0,0,0));
    tbl.push_back(row(0,1,0,'h00, 0,0,'h00, 0,1, 0,1,'h13,4'hF,0,0,0,0));
    // Reset, then round-robin with both sources always valid
    tbl.push_back(row(1,1,0,'h00, 0,0,'h00, 0,1, 0,1,'h13,4'hF,0,0,0,0));
    tbl.push_back(row(0,1,1,'hA0, 0,1,'hB0, 0,1, 0,0,'h00,4'h0,0,0,0,0));
    tbl.push_back(row(0,1,1,'hA0, 0,1,'hB0, 0,1, 0,0,'h00,4'h0,1,0,0,1));
    tbl.push_back(row(0,1,1,'hA1, 1,1,'hB0, 0,1, 1,0,'hA0,4'hF,1,0,0,1));
    tbl.push_back(row(0,1,1,'hA0, 0,1,'hB0, 0,1, 1,1,'hA1,4'hF,0,0,0,0));
    tbl.push_back(row(0,1,1,'hA0, 0,1,'hB0, 0,1, 0,1,'hA1,4'hF,0,1,1,1));
    tbl.push_back(row(0,1,1,'hA0, 0,1,'hB1, 1,1, 1,0,'hB0,4'h5,0,1,1,1));
    tbl.push_back(row(0,1,1,'hA0, 0,1,'hB0, 0,1, 1,1,'hB1,4'h5,0,0,1,0));
    tbl.push_back(row(0,1,1,'hA0, 0,1,'hB0, 0,1, 0,1,'hB1,4'h5,1,0,0,1));
    tbl.push_back(row(0,1,1,'hA1, 1,1,'hB0, 0,1, 1,0,'hA0,4'hF,1,0,0,1));
    tbl.push_back(row(0,1,0,'h00, 0,0,'h00, 0,1, 1,1,'hA1,4'hF,0,0,0,0));
    tbl.push_back(row(0,1,0,'h00, 0,0,'h00, 0,1, 0,1,'hA1,4'hF,0,0,0,0));
    // Backpressure: sink stalls 5 cycles mid-packet
    tbl.push_back(row(0,1,1,'h20, 0,0,'h00, 0,1, 0,1,'hA1,4'hF,0,0,0,0));
    tbl.push_back(row(0,1,1,'h20, 0,0,'h00, 0,1, 0,1,'hA1,4'hF,1,0,0,1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(row(0,1,1,'h21, 0,0,'h00, 0,0, 1,0,'h20,4'hF,0,0,0,1));
    tbl.push_back(row(0,1,1,'h21, 0,0,'h00, 0,1, 1,0,'h20,4'hF,1,0,0,1));
    tbl.push_back(row(0,1,1,'h22, 0,0,'h00, 0,1, 1,0,'h21,4'hF,1,0,0,1));
    tbl.push_back(row(0,1,1,'h23, 1,0,'h00, 0,1, 1,0,'h22,4'hF,1,0,0,1));
    tbl.push_back(row(0,1,0,'h00, 0,0,'h00, 0,1, 1,1,'h23,4'hF,0,0,0,0));
    tbl.push_back(row(0,1,0,'h00, 0,0,'h00, 0,1, 0,1,'h23,4'hF,0,0,0,0));
    // arb_enable dropped during beat 2 of an s01 packet; single-beat s00 packet after
    tbl.push_back(row(0,1,0,'h00, 0,1,'h30, 0,1, 0,1,'h23,4'hF,0,0,0,0));
    tbl.push_back(row(0,1,0,'h00, 0,1,'h30, 0,1, 0,1,'h23,4'hF,0,1,1,1));
    tbl.push_back(row(0,0,0,'h00, 0,1,'h31, 0,1, 1,0,'h30,4'h5,0,1,1,1));
    tbl.push_back(row(0,0,1,'h40, 1,1,'h32, 0,1, 1,0,'h31,4'h5,0,1,1,1));
    tbl.push_back(row(0,0,1,'h40, 1,1,'h33, 1,1, 1,0,'h32,4'h5,0,1,1,1));
    tbl.push_back(row(0,0,1,'h40, 1,0,'h00, 0,1, 1,1,'h33,4'h5,0,0,1,0));
    tbl.push_back(row(0,0,1,'h40, 1,0,'h00, 0,1, 0,1,'h33,4'h5,0,0,1,0));
    tbl.push_back(row(0,1,1,'h40, 1,0,'h00, 0,1, 0,1,'h33,4'h5,0,0,1,0));
    tbl.push_back(row(0,1,1,'h40, 1,0,'h00, 0,1, 0,1,'h33,4'h5,1,0,0,1));
    tbl.push_back(row(0,1,0,'h00, 0,0,'h00, 0,1, 1,1,'h40,4'hF,0,0,0,0));
    tbl.push_back(row(0,1,0,'h00, 0,0,'h00, 0,1, 0,1,'h40,4'hF,0,0,0,0));
    // Reset mid-packet on s01; afterwards s00 wins the first contested grant
    tbl.push_back(row(0,1,0,'h00, 0,1,'h50, 0,1, 0,1,'h40,4'hF,0,0,0,0));
    tbl.push_back(row(0,1,0,'h00, 0,1,'h50, 0,1, 0,1,'h40,4'hF,0,1,1,1));
    tbl.push_back(row(1,1,0,'h00, 0,1,'h51, 0,1, 1,0,'h50,4'h5,0,1,1,1));
    tbl.push_back(row(0,1,1,'h60, 0,1,'h51, 0,1, 0,0,'h00,4'h0,0,0,0,0));
    tbl.push_back(row(0,1,1,'h60, 0,1,'h51, 0,1, 0,0,'h00,4'h0,1,0,0,1));
    tbl.push_back(row(0,1,1,'h61, 1,1,'h51, 0,1, 1,0,'h60,4'hF,1,0,0,1));
    tbl.push_back(row(0,1,0,'h00, 0,0,'h00, 0,1, 1,1,'h61,4'hF,0,0,0,0));
    tbl.push_back(row(0,1,0,'h00, 0,0,'h00, 0,1, 0,1,'h61,4'hF,0,0,0,0));

    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    for (int k = 0; k < tbl.size(); k++) begin
      if (k > 0) @(negedge clk);
      rst = tbl[k].i.rst; en = tbl[k].i.en; m_r = tbl[k].i.mrdy;
      drive(tbl[k].i.v0, tbl[k].i.d0, tbl[k].i.l0, tbl[k].i.v1, tbl[k].i.d1, tbl[k].i.l1);
      #1;
      act = {m_v, m_l, m_d, m_s, s0_r, s1_r, gid, busy};
      checks++;
      if (act !== tbl[k].o) begin
        errors++;
        $display("FAIL row %0d: got vld=%b last=%b dat=%h strb=%h rdy0=%b rdy1=%b gid=%b busy=%b, expected vld=%b last=%b dat=%h strb=%h rdy0=%b rdy1=%b gid=%b busy=%b",
                 k, act.vld, act.last, act.dat, act.strb, act.r0, act.r1, act.gid, act.busy,
                 tbl[k].o.vld, tbl[k].o.last, tbl[k].o.dat, tbl[k].o.strb,
                 tbl[k].o.r0, tbl[k].o.r1, tbl[k].o.gid, tbl[k].o.busy);
      end
    end

    // Granted source (s01) pauses mid-packet: grant held, s00 keeps waiting.
    @(negedge clk); m_r = 1'b1; en = 1'b1; rst = 1'b0;
    drive(1'b1, 'h80, 1'b1, 1'b1, 'h70, 1'b0); #1;
    chk("gap_h0_busy", busy, 0);
    @(negedge clk); #1;
    chk("gap_h1_rdy1", s1_r, 1);
    chk("gap_h1_gid", gid, 1);
    @(negedge clk); drive(1'b1, 'h80, 1'b1, 1'b0, 'h00, 1'b0); #1;
    chk("gap_h2_rdy0", s0_r, 0);
    chk("gap_h2_dat", m_d, 'h70);
    @(negedge clk); #1;
    chk("gap_h3_busy", busy, 1);
    chk("gap_h3_rdy0", s0_r, 0);
    chk("gap_h3_vld", m_v, 0);
    @(negedge clk); drive(1'b1, 'h80, 1'b1, 1'b1, 'h71, 1'b1); #1;
    chk("gap_h4_rdy1", s1_r, 1);
    @(negedge clk); drive(1'b1, 'h80, 1'b1, 1'b0, 'h00, 1'b0); #1;
    chk("gap_h5_busy", busy, 0);
    chk("gap_h5_dat", m_d, 'h71);
    chk("gap_h5_last", m_l, 1);
    @(negedge clk); #1;
    chk("gap_h6_rdy0", s0_r, 1);
    chk("gap_h6_gid", gid, 0);
    @(negedge clk); drive(1'b0, 'h00, 1'b0, 1'b0, 'h00, 1'b0); #1;
    chk("gap_h7_dat", m_d, 'h80);
    chk("gap_h7_last", m_l, 1);

`ifdef AXIS_RR_ARBITER_STATS_EN
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("stats_reset0", cnt0, 0);
    chk("stats_reset1", cnt1, 0);
    send_pkt(0, 2); send_pkt(1, 3); send_pkt(0, 1); send_pkt(1, 1); send_pkt(0, 2);
    repeat (2) @(negedge clk);
    #1;
    chk("stats_count0", cnt0, 3);
    chk("stats_count1", cnt1, 2);
    @(negedge clk);
    force dut.pkt_count0_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.pkt_count0_q;
    #1;
    chk("stats_preload", cnt0, 32'hFFFF_FFFF);
    send_pkt(0, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("stats_wrap0", cnt0, 0);
    chk("stats_keep1", cnt1, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
